// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
// Arbitrates a single-port, byte-wide, synchronous-read instruction memory
// between the boot loader (byte writes) and the core fetch path (32-bit
// big-endian instruction reads assembled from four consecutive bytes).
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-low reset
//   fetch_req, PC       : fetch request and its byte address (held until valid)
//   instrCode           : assembled instruction, held until the next fetch ends
//   instr_valid         : one-cycle pulse, instrCode is new
//   fetch_fault         : qualifies instr_valid, PC misaligned / out of range
//   fetch_busy          : memory owned by a fetch or a loader write
//   ld_wr_en/addr/data  : loader byte write request (held until ld_ack)
//   ld_ack              : one-cycle pulse, the write was performed
//   mem_addr/re/we/wdata: memory command (all registered)
//   mem_rdata           : memory read byte, valid the cycle after mem_re
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       PC,
    output logic [31:0]       instrCode,
    output logic              instr_valid,
    output logic              fetch_fault,
    output logic              fetch_busy,
    input  logic              ld_wr_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RD    = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pc_lat_q, pc_lat_d;
    logic [31:0]         shadow_q, shadow_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                pc_bad_c;

    // Misaligned or beyond the memory depth: such a PC never touches memory
    assign pc_bad_c = (PC[1:0] != 2'b00) || ((PC >> ADDR_W) != 32'd0);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            pc_lat_q <= '0;
            shadow_q <= '0;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            maddr_q  <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_lat_q <= pc_lat_d;
            shadow_q <= shadow_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            maddr_q  <= maddr_d;
            re_q     <= re_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next state: requests are only arbitrated in IDLE/DONE, loader first
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_lat_d = pc_lat_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (ld_wr_en) begin
                    state_d = S_LOAD;
                end else if (fetch_req && !pc_bad_c) begin
                    state_d  = S_RD;
                    cnt_d    = 2'd0;
                    pc_lat_d = PC[ADDR_W-1:0];
                end else if (fetch_req) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD:  state_d = S_IDLE;
            S_RD: begin
                if (cnt_q == 2'd3) state_d = S_DRAIN;
                else               cnt_d   = cnt_q + 2'd1;
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it
    always_comb begin
        shadow_d = shadow_q;
        instr_d  = instr_q;
        valid_d  = 1'b0;
        fault_d  = 1'b0;
        busy_d   = 1'b0;
        ack_d    = 1'b0;
        maddr_d  = maddr_q;
        re_d     = 1'b0;
        we_d     = 1'b0;
        wdata_d  = wdata_q;

        // Read data lags the strobe by one cycle: byte k lands while cnt_q == k+1
        if (state_q == S_RD) begin
            unique case (cnt_q)
                2'd1:    shadow_d[31:24] = mem_rdata;
                2'd2:    shadow_d[23:16] = mem_rdata;
                2'd3:    shadow_d[15:8]  = mem_rdata;
                default: ;
            endcase
        end else if (state_q == S_DRAIN) begin
            shadow_d[7:0] = mem_rdata;
        end

        unique case (state_d)
            S_LOAD: begin
                busy_d  = 1'b1;
                we_d    = 1'b1;
                ack_d   = 1'b1;
                maddr_d = ld_addr;
                wdata_d = ld_data;
            end
            S_RD: begin
                busy_d  = 1'b1;
                re_d    = 1'b1;
                maddr_d = pc_lat_d + ADDR_W'(cnt_d);
            end
            S_DRAIN: busy_d = 1'b1;
            S_DONE: begin
                valid_d = 1'b1;
                // Only a DRAIN predecessor means real data; otherwise it was a bad PC
                if (state_q == S_DRAIN) begin
                    instr_d = {shadow_q[31:8], mem_rdata};
                end else begin
                    instr_d = NOP_INSTR;
                    fault_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign instrCode   = instr_q;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;
    assign fetch_busy  = busy_q;
    assign ld_ack      = ack_q;
    assign mem_addr    = maddr_q;
    assign mem_re      = re_q;
    assign mem_we      = we_q;
    assign mem_wdata   = wdata_q;

endmodule
